// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit. It issues one memory read, holds the
// returned instruction until downstream accepts it, then steps or redirects the PC.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        NextPCSrc,
   input  logic [31:0] ALURes,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Inst,
   output logic        InstValid,
   input  logic        InstReady,
   output logic [31:0] PC,
   output logic [31:0] PCInc,
   output logic        Fault,
   output logic [31:0] RetireCnt
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] retire_q, retire_d;
   logic        fault_q, fault_d;
   logic        handoff;
   logic        misaligned;

   assign handoff    = (state_q == HOLD) && InstReady;
   assign misaligned = NextPCSrc && (ALURes[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         inst_q   <= 32'h0;
         retire_q <= 32'h0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         retire_q <= retire_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = REQ;
         REQ:     if (imem_rvalid) state_d = HOLD;
         HOLD:    if (handoff) state_d = misaligned ? FAULT : REQ;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates: capture only in REQ, redirect/retire only on handoff.
   always_comb begin
      pc_d     = pc_q;
      inst_d   = inst_q;
      retire_d = retire_q;
      fault_d  = fault_q;
      if ((state_q == REQ) && imem_rvalid) begin
         inst_d = imem_rdata;
      end
      if (handoff) begin
         retire_d = retire_q + 32'd1;
         if (!NextPCSrc) begin
            pc_d = pc_q + 32'd4;
         end else if (!misaligned) begin
            pc_d = ALURes;
         end else begin
            fault_d = 1'b1;
         end
      end
   end

   always_comb begin
      imem_req  = 1'b0;
      InstValid = 1'b0;
      case (state_q)
         REQ:     imem_req  = 1'b1;
         HOLD:    InstValid = 1'b1;
         default: ;
      endcase
   end

   assign imem_addr = pc_q;
   assign Inst      = inst_q;
   assign PC        = pc_q;
   assign PCInc     = pc_q + 32'd4;
   assign Fault     = fault_q;
   assign RetireCnt = retire_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-by-cycle directed bench for fetch_unit: each table row gives the inputs
// for one cycle and the outputs expected during that cycle, before its clock edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        NextPCSrc;
   logic [31:0] ALURes;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] Inst;
   logic        InstValid;
   logic        InstReady;
   logic [31:0] PC;
   logic [31:0] PCInc;
   logic        Fault;
   logic [31:0] RetireCnt;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .ALURes(ALURes),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .Inst(Inst), .InstValid(InstValid),
      .InstReady(InstReady), .PC(PC), .PCInc(PCInc), .Fault(Fault),
      .RetireCnt(RetireCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        nsrc;
      logic [31:0] alu;
      logic        chk;
      logic        e_req;
      logic        e_val;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic [31:0] e_pcinc;
      logic        e_flt;
      logic [31:0] e_ret;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic rv, input logic [31:0] rd,
                      input logic rdy, input logic ns, input logic [31:0] alu,
                      input logic chk, input logic ereq, input logic evld,
                      input logic [31:0] einst, input logic [31:0] epc,
                      input logic [31:0] epcinc, input logic eflt,
                      input logic [31:0] eret);
      vec_t v;
      v.rst = r; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.nsrc = ns; v.alu = alu;
      v.chk = chk; v.e_req = ereq; v.e_val = evld; v.e_inst = einst; v.e_pc = epc;
      v.e_pcinc = epcinc; v.e_flt = eflt; v.e_ret = eret;
      vecs.push_back(v);
   endtask

   task automatic cmp(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; NextPCSrc = 1'b0; ALURes = 32'h0; imem_rvalid = 1'b0;
      imem_rdata = 32'h0; InstReady = 1'b0;

      //   rst rv rdata          rdy ns alu            chk req vld inst           pc             pcinc          flt ret
      add(1, 0, 32'h0,          0, 0, 32'h0,          0,  0,  0, 32'h0,          32'h0,         32'h4,         0,  0);
      add(1, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          1,  0,  0, 32'h0,          32'h0,         32'h4,         0,  0);
      add(0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          1,  0,  0, 32'h0,          32'h0,         32'h4,         0,  0);
      add(0, 1, 32'h0000_0013,  1, 0, 32'h0,          1,  1,  0, 32'h0,          32'h0,         32'h4,         0,  0);
      add(0, 0, 32'h0,          1, 0, 32'h0,          1,  0,  1, 32'h13,         32'h0,         32'h4,         0,  0);
      for (int i = 0; i < 5; i++)
         add(0, 0, 32'h1234_5678, 1, 0, 32'h0,        1,  1,  0, 32'h13,         32'h4,         32'h8,         0,  1);
      add(0, 1, 32'hAAAA_0001,  0, 0, 32'h0,          1,  1,  0, 32'h13,         32'h4,         32'h8,         0,  1);
      for (int i = 0; i < 3; i++)
         add(0, 1, 32'h5555_5555, 0, 1, 32'h80,       1,  0,  1, 32'hAAAA_0001,  32'h4,         32'h8,         0,  1);
      add(0, 0, 32'h0,          1, 1, 32'h10,         1,  0,  1, 32'hAAAA_0001,  32'h4,         32'h8,         0,  1);
      add(0, 1, 32'h22,         0, 0, 32'h0,          1,  1,  0, 32'hAAAA_0001,  32'h10,        32'h14,        0,  2);
      add(0, 0, 32'h0,          1, 1, 32'h40,         1,  0,  1, 32'h22,         32'h10,        32'h14,        0,  2);
      add(0, 1, 32'h33,         0, 0, 32'h0,          1,  1,  0, 32'h22,         32'h40,        32'h44,        0,  3);
      add(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  1,  0,  1, 32'h33,         32'h40,        32'h44,        0,  3);
      add(0, 1, 32'h44,         0, 0, 32'h0,          1,  1,  0, 32'h33,         32'hFFFF_FFFC, 32'h0,         0,  4);
      add(0, 0, 32'h0,          1, 0, 32'h0,          1,  0,  1, 32'h44,         32'hFFFF_FFFC, 32'h0,         0,  4);
      add(0, 1, 32'h55,         0, 0, 32'h0,          1,  1,  0, 32'h44,         32'h0,         32'h4,         0,  5);
      add(0, 0, 32'h0,          1, 1, 32'h42,         1,  0,  1, 32'h55,         32'h0,         32'h4,         0,  5);
      add(0, 1, 32'h99,         1, 0, 32'h0,          1,  0,  0, 32'h55,         32'h0,         32'h4,         1,  6);
      add(0, 1, 32'h99,         1, 1, 32'h100,        1,  0,  0, 32'h55,         32'h0,         32'h4,         1,  6);
      add(1, 0, 32'h0,          0, 0, 32'h0,          1,  0,  0, 32'h55,         32'h0,         32'h4,         1,  6);
      add(0, 0, 32'h0,          0, 0, 32'h0,          1,  0,  0, 32'h0,          32'h0,         32'h4,         0,  0);
      add(1, 1, 32'h66,         0, 0, 32'h0,          1,  1,  0, 32'h0,          32'h0,         32'h4,         0,  0);
      add(0, 0, 32'h0,          0, 0, 32'h0,          1,  0,  0, 32'h0,          32'h0,         32'h4,         0,  0);
      add(0, 0, 32'h0,          0, 0, 32'h0,          1,  1,  0, 32'h0,          32'h0,         32'h4,         0,  0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata;
         InstReady = vecs[i].rdy; NextPCSrc = vecs[i].nsrc; ALURes = vecs[i].alu;
         #1;
         if (vecs[i].chk) begin
            cmp("imem_req",  i, {31'h0, imem_req},  {31'h0, vecs[i].e_req});
            cmp("InstValid", i, {31'h0, InstValid}, {31'h0, vecs[i].e_val});
            cmp("Inst",      i, Inst,               vecs[i].e_inst);
            cmp("PC",        i, PC,                 vecs[i].e_pc);
            cmp("PCInc",     i, PCInc,              vecs[i].e_pcinc);
            cmp("Fault",     i, {31'h0, Fault},     {31'h0, vecs[i].e_flt});
            cmp("RetireCnt", i, RetireCnt,          vecs[i].e_ret);
            if (vecs[i].e_req) cmp("imem_addr", i, imem_addr, vecs[i].e_pc);
         end
      end

      // Hand sequence: DUT sits in REQ at PC 0; deliver data late and wait for it.
      @(negedge clk);
      imem_rvalid = 1'b0; InstReady = 1'b0;
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0077;
      @(negedge clk);
      imem_rvalid = 1'b0;
      begin
         int n = 0;
         while (!InstValid && n < 10) begin
            @(negedge clk);
            n++;
         end
         cmp("late_wait_valid", 100, {31'h0, InstValid}, 32'h1);
      end
      cmp("late_inst", 100, Inst, 32'h77);
      InstReady = 1'b1; NextPCSrc = 1'b0;
      @(negedge clk);
      InstReady = 1'b0;
      #1;
      cmp("late_addr", 101, imem_addr, 32'h4);
      cmp("late_ret",  101, RetireCnt, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
